// File: rtl/universal_shift_register.sv
// WIDTH-bit clock-enabled register with hold/load/shift/rotate/clear modes
// plus an autonomous LSB-first serial transmit sequence with busy/done status.
module universal_shift_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             serial_in,
  output logic [WIDTH-1:0] Q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int             CW         = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, XMIT} state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             done_q;

  // Next register value for IDLE-state commands; transmit start loads D.
  always_comb begin
    q_d = q_q;
    case (mode)
      3'b000:  q_d = q_q;
      3'b001:  q_d = D;
      3'b010:  q_d = {q_q[WIDTH-2:0], serial_in};
      3'b011:  q_d = {serial_in, q_q[WIDTH-1:1]};
      3'b100:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      3'b101:  q_d = {q_q[0], q_q[WIDTH-1:1]};
      3'b110:  q_d = '0;
      3'b111:  q_d = D;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      q_q     <= RESET_VALUE;
      done_q  <= 1'b0;
    end else if (!enable) begin
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          q_q <= q_d;
          if (mode == 3'b111) begin
            count_q <= LAST_COUNT;
            state_q <= XMIT;
          end
        end
        XMIT: begin
          // Final edge leaves Q untouched so the last bit stays visible.
          if (count_q != '0) begin
            q_q     <= {serial_in, q_q[WIDTH-1:1]};
            count_q <= count_q - 1'b1;
          end else begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Q          = q_q;
  assign serial_out = q_q[0];
  assign busy       = (state_q == XMIT);
  assign done       = done_q;

endmodule
